gsquare_b: RTL and testbench



---
 rtl/unary_kernel_pkg.sv | 15 +
 rtl/unary_regen.sv | 39 +++
 rtl/gsquare_b.sv | 75 +++++++
 tb/tb_gsquare_b.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/unary_kernel_pkg.sv
// Shared types and saturating helpers for the unary (stochastic) kernel family.
// Helpers work on 32-bit containers; callers cast to their own counter width.
package unary_kernel_pkg;

    typedef enum logic {WARM, RUN} gsq_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic [31:0] top);
        return (v >= top) ? v : v + 32'd1;
    endfunction

    function automatic logic [31:0] sat_dec(input logic [31:0] v);
        return (v == 32'd0) ? v : v - 32'd1;
    endfunction

endpackage

// File: rtl/unary_regen.sv
// Regenerates a decorrelated copy of a unary stream: saturating up/down counter vs. random number.
// regen is combinational from the pre-edge count; the counter holds while en is low.
module unary_regen
    import unary_kernel_pkg::*;
#(
    parameter int BW = 5
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          en,
    input  logic [BW:0]   randNum,
    input  logic          in,
    output logic          regen
);

    localparam int        CW      = BW + 1;
    localparam logic [BW:0] CNT_MID = CW'(1) << BW;
    localparam logic [BW:0] CNT_MAX = '1;

    logic [BW:0] r_cnt;
    logic        w_regen;

    assign w_regen = (r_cnt > randNum);
    assign regen   = w_regen;

    // Counter tracks the input: step toward p whenever the regenerated bit disagrees with it.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= CNT_MID;
        end else if (en) begin
            if (in && !w_regen) begin
                r_cnt <= CW'(sat_inc(32'(r_cnt), 32'(CNT_MAX)));
            end else if (!in && w_regen) begin
                r_cnt <= CW'(sat_dec(32'(r_cnt)));
            end
        end
    end

endmodule

// File: rtl/gsquare_b.sv
// Unary squarer: out = in AND decorrelated regen(in), probability ~p^2, one cycle registered latency.
// Outputs forced low during a WARM-cycle warm-up; everything holds while en is low.
module gsquare_b
    import unary_kernel_pkg::*;
#(
    parameter int BW   = 5,
    parameter int WARM = 32
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic [BW:0] randNum,
    input  logic        in,
    output logic        out,
    output logic        valid
);

    localparam int WCW = $clog2(WARM + 1);

    gsq_state_t     r_state;
    gsq_state_t     w_state_nxt;
    logic [WCW-1:0] r_warm_cnt;
    logic           r_out;
    logic           r_valid;
    logic           w_out_nxt;
    logic           w_valid_nxt;
    logic           w_regen;

    unary_regen #(
        .BW(BW)
    ) u_regen (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .randNum (randNum),
        .in      (in),
        .regen   (w_regen)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_out_nxt   = 1'b0;
        w_valid_nxt = 1'b0;
        if (r_state == unary_kernel_pkg::WARM) begin
            // valid rises on the very edge that leaves warm-up; out stays low on that edge.
            if (r_warm_cnt == WCW'(WARM - 1)) begin
                w_state_nxt = RUN;
                w_valid_nxt = 1'b1;
            end
        end else begin
            w_out_nxt   = in & w_regen;
            w_valid_nxt = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= unary_kernel_pkg::WARM;
            r_warm_cnt <= '0;
            r_out      <= 1'b0;
            r_valid    <= 1'b0;
        end else if (en) begin
            r_state <= w_state_nxt;
            r_out   <= w_out_nxt;
            r_valid <= w_valid_nxt;
            if (r_state == unary_kernel_pkg::WARM) begin
                r_warm_cnt <= r_warm_cnt + WCW'(1);
            end
        end
    end

    assign out   = r_out;
    assign valid = r_valid;

endmodule

// File: tb/tb_gsquare_b.sv
// Directed bench for gsquare_b: warm-up, saturation, statistics, enable stall, mid-run reset.
module tb_gsquare_b;

    localparam int BW   = 5;
    localparam int WARM = 32;
    localparam int CMAX = (1 << (BW + 1)) - 1;

    logic        clk = 1'b0;
    logic        rst;
    logic        en;
    logic        in;
    logic [BW:0] randNum;
    logic        out;
    logic        valid;

    int n_checks = 0;
    int n_errors = 0;

    // reference model state
    int m_cnt;
    int m_wc;
    bit m_run;
    bit m_out;
    bit m_valid;

    always #5 clk = ~clk;

    gsquare_b #(
        .BW   (BW),
        .WARM (WARM)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .randNum (randNum),
        .in      (in),
        .out     (out),
        .valid   (valid)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
        end
    endtask

    task automatic model_step(input bit r, input bit e, input bit i, input int rn);
        bit rg;
        rg = (m_cnt > rn);
        if (r) begin
            m_cnt = 1 << BW; m_run = 0; m_wc = 0; m_out = 0; m_valid = 0;
        end else if (e) begin
            m_out   = m_run ? (i & rg) : 1'b0;
            m_valid = m_run || (m_wc == WARM - 1);
            if (!m_run) begin
                if (m_wc == WARM - 1) m_run = 1;
                m_wc++;
            end
            if (i && !rg)      m_cnt = (m_cnt == CMAX) ? CMAX : m_cnt + 1;
            else if (!i && rg) m_cnt = (m_cnt == 0) ? 0 : m_cnt - 1;
        end
    endtask

    task automatic step(input bit r, input bit e, input bit i, input int rn);
        rst     = r;
        en      = e;
        in      = i;
        randNum = (BW + 1)'(rn);
        @(posedge clk);
        model_step(r, e, i, rn);
        #1;
    endtask

    task automatic check_model(input string tag);
        check({tag, "_cnt"},   32'(dut.u_regen.r_cnt), 32'(m_cnt));
        check({tag, "_out"},   32'(out),               32'(m_out));
        check({tag, "_valid"}, 32'(valid),             32'(m_valid));
    endtask

    initial begin
        int ones;
        int cnt_sum;
        int bad;
        rst = 1'b1; en = 1'b0; in = 1'b0; randNum = '0;
        m_cnt = 0; m_wc = 0; m_run = 0; m_out = 0; m_valid = 0;

        // reset with en low: rst must still win
        step(1, 0, 0, 0);
        check("rst_cnt",   32'(dut.u_regen.r_cnt), 32);
        check("rst_out",   32'(out),               0);
        check("rst_valid", 32'(valid),             0);
        check("rst_warm",  32'(dut.r_warm_cnt),    0);
        check("rst_state", 32'(dut.r_state),       0);

        // warm-up: in=1, randNum=0 -> regen=1, cnt holds at 32
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 1, 0);
            check($sformatf("warm_valid_%0d", k), 32'(valid), (k >= 32) ? 1 : 0);
            check($sformatf("warm_out_%0d", k),   32'(out),   (k >= 33) ? 1 : 0);
        end
        check("warm_cnt_hold", 32'(dut.u_regen.r_cnt), 32);
        check("warm_state",    32'(dut.r_state),       1);

        // saturate up: randNum=63 -> regen never 1
        step(1, 1, 1, 63);
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 1, 63);
            check($sformatf("satup_cnt_%0d", k), 32'(dut.u_regen.r_cnt), (32 + k > 63) ? 63 : 32 + k);
            check($sformatf("satup_out_%0d", k), 32'(out), 0);
        end

        // saturate down: in=0, randNum=0
        step(1, 1, 0, 0);
        for (int k = 1; k <= 40; k++) begin
            step(0, 1, 0, 0);
            check($sformatf("satdn_cnt_%0d", k), 32'(dut.u_regen.r_cnt), (32 - k < 0) ? 0 : 32 - k);
            check($sformatf("satdn_out_%0d", k), 32'(out), 0);
        end
        check("satdn_regen_zero", 32'(dut.w_regen), 0);

        // statistical square at p=0.5
        step(1, 1, 0, 0);
        for (int k = 0; k < WARM; k++) step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
        ones = 0; cnt_sum = 0; bad = 0;
        for (int k = 0; k < 4096; k++) begin
            step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            ones    += int'(out);
            cnt_sum += int'(dut.u_regen.r_cnt);
            if (out !== m_out || valid !== m_valid || int'(dut.u_regen.r_cnt) != m_cnt) bad++;
        end
        check("stat_model_mismatches", 32'(bad), 0);
        check("stat_ones_in_1024pm100", 32'((ones >= 924 && ones <= 1124) ? 1 : 0), 1);
        check("stat_cnt_mean_32pm8", 32'((cnt_sum / 4096 >= 24 && cnt_sum / 4096 <= 40) ? 1 : 0), 1);

        // enable stall in RUN: toggling inputs must not move anything
        for (int k = 0; k < 10; k++) begin
            step(0, 0, 1'(k & 1), (k * 7) % 64);
            check_model($sformatf("stall_%0d", k));
            check($sformatf("stall_state_%0d", k), 32'(dut.r_state), 1);
        end
        for (int k = 0; k < 20; k++) begin
            step(0, 1, 1'($urandom_range(0, 1)), int'($urandom_range(0, 63)));
            check_model($sformatf("resume_%0d", k));
        end

        // mid-run reset with cnt=50
        step(1, 1, 1, 0);
        for (int k = 0; k < WARM; k++) step(0, 1, 1, 0);
        for (int k = 0; k < 18; k++) step(0, 1, 1, 63);
        check("mrst_pre_cnt",   32'(dut.u_regen.r_cnt), 50);
        check("mrst_pre_valid", 32'(valid),             1);
        step(1, 1, 1, 63);
        check("mrst_cnt",   32'(dut.u_regen.r_cnt), 32);
        check("mrst_valid", 32'(valid),             0);
        check("mrst_out",   32'(out),               0);
        check("mrst_warm",  32'(dut.r_warm_cnt),    0);
        for (int k = 1; k <= WARM; k++) begin
            step(0, 1, 1, 0);
            if (k == WARM - 1) check("mrst_valid_before", 32'(valid), 0);
            if (k == WARM)     check("mrst_valid_after",  32'(valid), 1);
        end

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
